mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Clocked load/store sequencer between the CPU datapath and the byte-addressed 512x8 RAM.
//  Accepts one request at a time and maps MIPS load/store opcodes onto the RAM's op codes.
//  Drives the RAM handshake (MOV/ReadWrite, waits on MOC), sign-extends LB/LH data,
//  bounds-checks addresses and times out hung accesses.
// PARAMETERS
//  ADDR_MAX        511  highest valid byte address; access last byte = addr+size-1 must be <= ADDR_MAX
//  TIMEOUT_CYCLES  16   max WAIT cycles before an access is aborted with err
// PORTS
//  clk       in   1   single clock, all state on posedge
//  reset     in   1   synchronous, active-high
//  req       in   1   request strobe, sampled in IDLE only
//  op        in   6   MIPS opcode: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101,
//                     SB 101000, SH 101001, SW 101011
//  addr      in   32  byte address
//  wdata     in   32  store data (right-justified for SB/SH)
//  busy      out  1   high from accept until the done cycle (inclusive)
//  done      out  1   one-cycle completion pulse
//  err       out  1   valid with done; request aborted or rejected
//  rdata     out  32  load result, held until next load completes
//  mov       out  1   RAM MOV
//  rw        out  1   RAM ReadWrite (1 = read, 0 = write)
//  ram_addr  out  32  RAM Address
//  ram_din   out  32  RAM DataIn
//  ram_op    out  6   RAM OP
//  moc       in   1   RAM MOC
//  ram_dout  in   32  RAM DataOut
// BEHAVIOUR
//  Reset (sync, any state incl. mid-access): state=IDLE; busy, done, err, mov, rw, ram_addr,
//   ram_din, ram_op, rdata all 0; counter 0; in-flight request dropped, no done pulse.
//  FSM states IDLE, ISSUE, WAIT, FIN.
//  IDLE: req=1 -> latch op/addr/wdata, busy=1. Undefined op or out-of-range address
//   (or misalignment when ALIGN_CHECK_EN is defined) -> FIN with err=1, mov never raised.
//   Otherwise -> ISSUE.
//  ISSUE (1 cycle): mov 0->1; rw = op[3]==0; ram_addr, ram_din = latched values.
//   ram_op: LB->100100, LH->100101, all others passed unchanged. counter=0. -> WAIT.
//  WAIT: mov held 1. moc is ignored in the ISSUE cycle and sampled only in WAIT.
//   - moc=1: for loads, capture rdata -> FIN with err=0.
//     LB: {{24{d[7]}},d[7:0]}; LH: {{16{d[15]}},d[15:0]}; LBU/LHU/LW: d unchanged.
//   - moc=0: counter++. When counter reaches TIMEOUT_CYCLES -> FIN with err=1; rdata unchanged.
//  FIN (1 cycle): mov=0, done=1, err as decided; -> IDLE. busy=0 from the next cycle.
//  req outside IDLE is ignored, never queued. Minimum accept-to-done latency is 3 cycles
//   (ISSUE, WAIT with moc, FIN). Back-to-back: a new req is accepted on the cycle after FIN.
//  mov returns to 0 for at least 2 cycles (FIN plus the IDLE accept cycle) before re-raising,
//   so the RAM sees a fresh MOV posedge on every access.
//  Range check: size = 1/2/4 bytes; addr+size-1 is computed in 33 bits, so wrap past
//   2^32-1 is an error.
//  ram_addr, ram_din, ram_op hold their last values in IDLE (no glitching of the RAM inputs).
// CONFIGURATION
//  ALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0, is rejected
//   in IDLE (done+err, no RAM access).
//  ALIGN_CHECK_EN undefined: unaligned accesses pass straight to the RAM (big-endian byte
//   order), subject to the range check only.
// TESTING
//  1 SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> rdata=0xDEADBEEF, err=0, done 3 cycles after accept.
//  2 SB 0x20 wdata=0x80, then LB 0x20 -> rdata=0xFFFFFF80; LBU 0x20 -> 0x00000080.
//    SH 0x22 0x8001, then LH -> 0xFFFF8001.
//  3 LW addr=510 -> done+err, mov stays 0. LW 508 -> ok. SB 511 -> ok.
//  4 RAM model holds moc=0 -> err at WAIT cycle 16, mov drops in FIN, rdata unchanged.
//  5 reset asserted in WAIT -> next cycle mov=0, busy=0, no done; following LW completes normally.
//  6 LH addr=0x31: with ALIGN_CHECK_EN -> err, no access; without -> bytes 0x31,0x32 sign-extended.
//    Also op=6'b000000 -> err, no access (both builds).

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Bundle of the CPU-side request/response signals and the RAM handshake signals.
// The controller uses the slave modport; the environment (CPU + RAM) uses master.
interface mem_access_ctrl_if;
  logic        req;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mov;
  logic        rw;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [5:0]  ram_op;
  logic        moc;
  logic [31:0] ram_dout;

  modport slave (
    input  req, op, addr, wdata, moc, ram_dout,
    output busy, done, err, rdata, mov, rw, ram_addr, ram_din, ram_op
  );

  modport master (
    output req, op, addr, wdata, moc, ram_dout,
    input  busy, done, err, rdata, mov, rw, ram_addr, ram_din, ram_op
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the CPU datapath and a byte-addressed RAM (MOV/MOC handshake).
// Define ALIGN_CHECK_EN to reject unaligned halfword/word accesses before they reach the RAM.
module mem_access_ctrl #(
  parameter int unsigned ADDR_MAX       = 511,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               reset,
  mem_access_ctrl_if.slave  bus_io
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpLhu = 6'b100101;
  localparam logic [5:0] OpSb  = 6'b101000;
  localparam logic [5:0] OpSh  = 6'b101001;
  localparam logic [5:0] OpSw  = 6'b101011;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFin} state_e;

  state_e            state_q;
  logic [5:0]        op_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q, done_q, err_q, mov_q, rw_q;
  logic [31:0]       rdata_q, ram_addr_q, ram_din_q;
  logic [5:0]        ram_op_q;

  logic              op_ok, misalign, range_bad, reject;
  logic [2:0]        size;
  logic [32:0]       last_byte;
  logic [5:0]        ram_op_map;
  logic [31:0]       ld_data;

  // Request decode, evaluated on the live inputs while idle.
  always_comb begin
    op_ok    = 1'b1;
    size     = 3'd1;
    misalign = 1'b0;
    unique case (bus_io.op)
      OpLb, OpLbu, OpSb: size = 3'd1;
      OpLh, OpLhu, OpSh: size = 3'd2;
      OpLw, OpSw:        size = 3'd4;
      default:           op_ok = 1'b0;
    endcase
`ifdef ALIGN_CHECK_EN
    if (size == 3'd2) misalign = bus_io.addr[0];
    if (size == 3'd4) misalign = |bus_io.addr[1:0];
`else
    misalign = 1'b0;
`endif
    // 33-bit sum so an access wrapping past 2^32-1 is caught as out of range.
    last_byte  = {1'b0, bus_io.addr} + {30'd0, size} - 33'd1;
    range_bad  = last_byte > 33'(ADDR_MAX);
    reject     = !op_ok || range_bad || misalign;
    ram_op_map = (bus_io.op == OpLb) ? OpLbu :
                 (bus_io.op == OpLh) ? OpLhu : bus_io.op;
  end

  always_comb begin
    ld_data = bus_io.ram_dout;
    if (op_q == OpLb) ld_data = {{24{bus_io.ram_dout[7]}}, bus_io.ram_dout[7:0]};
    if (op_q == OpLh) ld_data = {{16{bus_io.ram_dout[15]}}, bus_io.ram_dout[15:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mov_q      <= 1'b0;
      rw_q       <= 1'b0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_op_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.req) begin
            op_q   <= bus_io.op;
            busy_q <= 1'b1;
            if (reject) begin
              state_q <= StFin;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q    <= StIssue;
              mov_q      <= 1'b1;
              rw_q       <= ~bus_io.op[3];
              ram_addr_q <= bus_io.addr;
              ram_din_q  <= bus_io.wdata;
              ram_op_q   <= ram_op_map;
              cnt_q      <= '0;
            end
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          if (bus_io.moc) begin
            if (!op_q[3]) rdata_q <= ld_data;
            mov_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            state_q <= StFin;
          end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            cnt_q   <= cnt_q + 1'b1;
            mov_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= StFin;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFin: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.busy     = busy_q;
  assign bus_io.done     = done_q;
  assign bus_io.err      = err_q;
  assign bus_io.rdata    = rdata_q;
  assign bus_io.mov      = mov_q;
  assign bus_io.rw       = rw_q;
  assign bus_io.ram_addr = ram_addr_q;
  assign bus_io.ram_din  = ram_din_q;
  assign bus_io.ram_op   = ram_op_q;

endmodule
